ddr_axi_traffic_gen: RTL and testbench

AXI4 initiator that drives one DDR channel of the shell DDR interface: it writes a seeded address-derived pattern across a programmed region in fixed-length INCR bursts, reads the region back and checks every beat. It is the traffic source connected to one channel of the DDR slave memory model in simulation and to the real DDR controller port in hardware bring-up. It supports one outstanding burst at a time, so its behaviour is fully deterministic for directed tests.

---
 rtl/ddr_axi_traffic_gen_if.sv | 68 ++++++
 rtl/ddr_axi_traffic_gen.sv | 271 +++++++++++++++++++++++++++
 tb/tb_ddr_axi_traffic_gen.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_axi_traffic_gen_if.sv
// AXI4 signal bundle for one shell DDR channel. The master modport is the traffic generator side
// and the slave modport is the memory or controller side.
interface ddr_axi_traffic_gen_if;
    logic [15:0]  cl_sh_ddr_awid;
    logic [63:0]  cl_sh_ddr_awaddr;
    logic [7:0]   cl_sh_ddr_awlen;
    logic [2:0]   cl_sh_ddr_awsize;
    logic [1:0]   cl_sh_ddr_awburst;
    logic         cl_sh_ddr_awvalid;
    logic         sh_cl_ddr_awready;

    logic [15:0]  cl_sh_ddr_wid;
    logic [511:0] cl_sh_ddr_wdata;
    logic [63:0]  cl_sh_ddr_wstrb;
    logic         cl_sh_ddr_wlast;
    logic         cl_sh_ddr_wvalid;
    logic         sh_cl_ddr_wready;

    logic [15:0]  sh_cl_ddr_bid;
    logic [1:0]   sh_cl_ddr_bresp;
    logic         sh_cl_ddr_bvalid;
    logic         cl_sh_ddr_bready;

    logic [15:0]  cl_sh_ddr_arid;
    logic [63:0]  cl_sh_ddr_araddr;
    logic [7:0]   cl_sh_ddr_arlen;
    logic [2:0]   cl_sh_ddr_arsize;
    logic [1:0]   cl_sh_ddr_arburst;
    logic         cl_sh_ddr_arvalid;
    logic         sh_cl_ddr_arready;

    logic [15:0]  sh_cl_ddr_rid;
    logic [511:0] sh_cl_ddr_rdata;
    logic [1:0]   sh_cl_ddr_rresp;
    logic         sh_cl_ddr_rlast;
    logic         sh_cl_ddr_rvalid;
    logic         cl_sh_ddr_rready;

    modport master (
        output cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awsize,
               cl_sh_ddr_awburst, cl_sh_ddr_awvalid,
        input  sh_cl_ddr_awready,
        output cl_sh_ddr_wid, cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
        input  sh_cl_ddr_wready,
        input  sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
        output cl_sh_ddr_bready,
        output cl_sh_ddr_arid, cl_sh_ddr_araddr, cl_sh_ddr_arlen, cl_sh_ddr_arsize,
               cl_sh_ddr_arburst, cl_sh_ddr_arvalid,
        input  sh_cl_ddr_arready,
        input  sh_cl_ddr_rid, sh_cl_ddr_rdata, sh_cl_ddr_rresp, sh_cl_ddr_rlast, sh_cl_ddr_rvalid,
        output cl_sh_ddr_rready
    );

    modport slave (
        input  cl_sh_ddr_awid, cl_sh_ddr_awaddr, cl_sh_ddr_awlen, cl_sh_ddr_awsize,
               cl_sh_ddr_awburst, cl_sh_ddr_awvalid,
        output sh_cl_ddr_awready,
        input  cl_sh_ddr_wid, cl_sh_ddr_wdata, cl_sh_ddr_wstrb, cl_sh_ddr_wlast, cl_sh_ddr_wvalid,
        output sh_cl_ddr_wready,
        output sh_cl_ddr_bid, sh_cl_ddr_bresp, sh_cl_ddr_bvalid,
        input  cl_sh_ddr_bready,
        input  cl_sh_ddr_arid, cl_sh_ddr_araddr, cl_sh_ddr_arlen, cl_sh_ddr_arsize,
               cl_sh_ddr_arburst, cl_sh_ddr_arvalid,
        output sh_cl_ddr_arready,
        output sh_cl_ddr_rid, sh_cl_ddr_rdata, sh_cl_ddr_rresp, sh_cl_ddr_rlast, sh_cl_ddr_rvalid,
        input  cl_sh_ddr_rready
    );
endinterface

// File: rtl/ddr_axi_traffic_gen.sv
// Single-outstanding AXI4 write-then-readback pattern generator for one DDR channel.
// Define DDR_TRAFFIC_GEN_CHECK_EN to build the read-data comparator.
module ddr_axi_traffic_gen (
    input  logic                  clk_core,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [63:0]           cfg_base,
    input  logic [7:0]            cfg_len,
    input  logic [15:0]           cfg_num,
    input  logic [31:0]           cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic [15:0]           err_cnt,
    ddr_axi_traffic_gen_if.master ddr
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [63:0]  base_q, base_d;
    logic [7:0]   len_q, len_d;
    logic [15:0]  num_q, num_d;
    logic [31:0]  seed_q, seed_d;
    logic [15:0]  burst_q, burst_d;
    logic [7:0]   beat_q, beat_d;
    logic [63:0]  burst_addr_q, burst_addr_d;
    logic [63:0]  beat_addr_q, beat_addr_d;
    logic         awvalid_q, awvalid_d;
    logic         wvalid_q, wvalid_d;
    logic         arvalid_q, arvalid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         cfg_err_q, cfg_err_d;
    logic [15:0]  err_cnt_q, err_cnt_d;

    logic         len_ok;
    logic [63:0]  burst_step;
    logic         last_beat;
    logic         last_burst;
    logic [511:0] exp_data;
    logic         aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic         data_bad;
    logic         rd_bad;
    logic         err_inc;
    logic         unused_in;

    always_comb begin
        case (cfg_len)
            8'd0, 8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63: len_ok = 1'b1;
            default:                                     len_ok = 1'b0;
        endcase
    end

    // Bytes per burst: (len + 1) beats of 64 B.
    assign burst_step = {49'd0, {1'b0, len_q} + 9'd1, 6'd0};
    assign last_beat  = (beat_q == len_q);
    assign last_burst = (burst_q == num_q - 16'd1);
    assign exp_data   = {16{beat_addr_q[31:0] ^ seed_q}};

    assign aw_hs = awvalid_q & ddr.sh_cl_ddr_awready;
    assign w_hs  = wvalid_q & ddr.sh_cl_ddr_wready;
    assign b_hs  = (state_q == StWrResp) & ddr.sh_cl_ddr_bvalid;
    assign ar_hs = arvalid_q & ddr.sh_cl_ddr_arready;
    assign r_hs  = (state_q == StRdData) & ddr.sh_cl_ddr_rvalid;

`ifdef DDR_TRAFFIC_GEN_CHECK_EN
    assign data_bad  = (ddr.sh_cl_ddr_rdata != exp_data);
    assign unused_in = ^{ddr.sh_cl_ddr_bid, ddr.sh_cl_ddr_rid};
`else
    assign data_bad  = 1'b0;
    assign unused_in = ^{ddr.sh_cl_ddr_bid, ddr.sh_cl_ddr_rid, ddr.sh_cl_ddr_rdata};
`endif

    // Read beat errors are OR-ed so one beat never counts more than once.
    assign rd_bad  = (ddr.sh_cl_ddr_rresp != 2'b00) | (ddr.sh_cl_ddr_rlast != last_beat) | data_bad;
    assign err_inc = (b_hs & (ddr.sh_cl_ddr_bresp != 2'b00)) | (r_hs & rd_bad);

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        len_d        = len_q;
        num_d        = num_q;
        seed_d       = seed_q;
        burst_d      = burst_q;
        beat_d       = beat_q;
        burst_addr_d = burst_addr_q;
        beat_addr_d  = beat_addr_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        arvalid_d    = arvalid_q;
        busy_d       = busy_q;
        done_d       = done_q;
        cfg_err_d    = cfg_err_q;
        err_cnt_d    = err_cnt_q;

        if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                if (start) begin
                    base_d       = cfg_base;
                    len_d        = cfg_len;
                    num_d        = cfg_num;
                    seed_d       = cfg_seed;
                    burst_d      = 16'd0;
                    burst_addr_d = cfg_base;
                    err_cnt_d    = 16'd0;
                    done_d       = 1'b0;
                    cfg_err_d    = 1'b0;
                    if (!len_ok) begin
                        cfg_err_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = StDone;
                    end else if (cfg_num == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = StWrAddr;
                    end
                end
            end
            StWrAddr: begin
                // First cycle in the state only raises awvalid; this also gives the B-to-AW gap.
                if (!awvalid_q) begin
                    awvalid_d = 1'b1;
                end else if (aw_hs) begin
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b1;
                    beat_d      = 8'd0;
                    beat_addr_d = burst_addr_q;
                    state_d     = StWrData;
                end
            end
            StWrData: begin
                if (w_hs) begin
                    if (last_beat) begin
                        wvalid_d = 1'b0;
                        state_d  = StWrResp;
                    end else begin
                        beat_d      = beat_q + 8'd1;
                        beat_addr_d = beat_addr_q + 64'd64;
                    end
                end
            end
            StWrResp: begin
                if (b_hs) begin
                    if (last_burst) begin
                        burst_d      = 16'd0;
                        burst_addr_d = base_q;
                        state_d      = StRdAddr;
                    end else begin
                        burst_d      = burst_q + 16'd1;
                        burst_addr_d = burst_addr_q + burst_step;
                        state_d      = StWrAddr;
                    end
                end
            end
            StRdAddr: begin
                if (!arvalid_q) begin
                    arvalid_d = 1'b1;
                end else if (ar_hs) begin
                    arvalid_d   = 1'b0;
                    beat_d      = 8'd0;
                    beat_addr_d = burst_addr_q;
                    state_d     = StRdData;
                end
            end
            StRdData: begin
                // Beat position is tracked locally; rlast only feeds the error check.
                if (r_hs) begin
                    if (!last_beat) begin
                        beat_d      = beat_q + 8'd1;
                        beat_addr_d = beat_addr_q + 64'd64;
                    end else if (last_burst) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        burst_d      = burst_q + 16'd1;
                        burst_addr_d = burst_addr_q + burst_step;
                        state_d      = StRdAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            base_q       <= 64'd0;
            len_q        <= 8'd0;
            num_q        <= 16'd0;
            seed_q       <= 32'd0;
            burst_q      <= 16'd0;
            beat_q       <= 8'd0;
            burst_addr_q <= 64'd0;
            beat_addr_q  <= 64'd0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            err_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            len_q        <= len_d;
            num_q        <= num_d;
            seed_q       <= seed_d;
            burst_q      <= burst_d;
            beat_q       <= beat_d;
            burst_addr_q <= burst_addr_d;
            beat_addr_q  <= beat_addr_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            arvalid_q    <= arvalid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign err_cnt = err_cnt_q;

    assign ddr.cl_sh_ddr_awid    = 16'd0;
    assign ddr.cl_sh_ddr_awaddr  = burst_addr_q;
    assign ddr.cl_sh_ddr_awlen   = len_q;
    assign ddr.cl_sh_ddr_awsize  = 3'd6;
    assign ddr.cl_sh_ddr_awburst = 2'b01;
    assign ddr.cl_sh_ddr_awvalid = awvalid_q;

    assign ddr.cl_sh_ddr_wid     = 16'd0;
    assign ddr.cl_sh_ddr_wdata   = exp_data;
    assign ddr.cl_sh_ddr_wstrb   = {64{1'b1}};
    assign ddr.cl_sh_ddr_wlast   = wvalid_q & last_beat;
    assign ddr.cl_sh_ddr_wvalid  = wvalid_q;

    assign ddr.cl_sh_ddr_bready  = (state_q == StWrResp);

    assign ddr.cl_sh_ddr_arid    = 16'd0;
    assign ddr.cl_sh_ddr_araddr  = burst_addr_q;
    assign ddr.cl_sh_ddr_arlen   = len_q;
    assign ddr.cl_sh_ddr_arsize  = 3'd6;
    assign ddr.cl_sh_ddr_arburst = 2'b01;
    assign ddr.cl_sh_ddr_arvalid = arvalid_q;

    assign ddr.cl_sh_ddr_rready  = (state_q == StRdData);

endmodule

// File: tb/tb_ddr_axi_traffic_gen.sv
// Randomized bench for ddr_axi_traffic_gen: a reactive AXI slave with a backing memory and
// arithmetic expectations for addresses, patterns and error counts.
`timescale 1ns/1ps
module tb_ddr_axi_traffic_gen;

`ifdef DDR_TRAFFIC_GEN_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif
    localparam logic [63:0] NoAddr = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk_core = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] cfg_base;
    logic [7:0]  cfg_len;
    logic [15:0] cfg_num;
    logic [31:0] cfg_seed;
    logic        busy, done, cfg_err;
    logic [15:0] err_cnt;

    always #5 clk_core = ~clk_core;

    ddr_axi_traffic_gen_if ddr ();

    ddr_axi_traffic_gen dut (
        .clk_core (clk_core),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .cfg_num  (cfg_num),
        .cfg_seed (cfg_seed),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .err_cnt  (err_cnt),
        .ddr      (ddr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Run description and slave-model knobs
    logic [63:0] m_base;
    int          m_len;
    int          m_num;
    logic [31:0] m_seed;
    int          ready_pct = 100;
    int          bresp_err_burst = -1;
    logic [63:0] corrupt_addr = NoAddr;
    logic [63:0] rresp_err_addr = NoAddr;
    logic [63:0] rlast_err_addr = NoAddr;

    // Observations
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, valid_seen, proto_err;
    logic [511:0] mem [logic [63:0]];
    logic [63:0]  rq [$];
    int           b_pend, w_beat, r_beat;
    logic [63:0]  w_addr;

    function automatic bit coin(input int pct);
        return $urandom_range(0, 99) < pct;
    endfunction

    function automatic logic [63:0] step_bytes(input int len);
        return 64'(len + 1) * 64'd64;
    endfunction

    // Slave: decides ready/valid at each falling edge; a handshake seen here completes at the next
    // rising edge.
    initial begin : slave
        logic aw_wait, w_wait, ar_wait, b_taken, r_taken;
        logic [63:0]  aw_p_addr, ar_p_addr;
        logic [7:0]   aw_p_len, ar_p_len;
        logic [511:0] w_p_data;
        logic         w_p_last;
        logic [63:0]  ra, ea;
        logic [31:0]  word;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_taken = 0; r_taken = 0;
        aw_p_addr = 0; ar_p_addr = 0; aw_p_len = 0; ar_p_len = 0; w_p_data = 0; w_p_last = 0;
        ddr.sh_cl_ddr_awready = 0; ddr.sh_cl_ddr_wready = 0; ddr.sh_cl_ddr_arready = 0;
        ddr.sh_cl_ddr_bvalid = 0; ddr.sh_cl_ddr_bresp = 0; ddr.sh_cl_ddr_bid = 0;
        ddr.sh_cl_ddr_rvalid = 0; ddr.sh_cl_ddr_rresp = 0; ddr.sh_cl_ddr_rid = 0;
        ddr.sh_cl_ddr_rdata = 0; ddr.sh_cl_ddr_rlast = 0;
        forever begin
            @(negedge clk_core);
            if (!rst_n) begin
                ddr.sh_cl_ddr_awready = 0; ddr.sh_cl_ddr_wready = 0; ddr.sh_cl_ddr_arready = 0;
                ddr.sh_cl_ddr_bvalid = 0; ddr.sh_cl_ddr_rvalid = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0; b_taken = 0; r_taken = 0;
                rq.delete(); b_pend = 0; w_beat = 0; r_beat = 0;
            end else begin
                if (aw_wait && (!ddr.cl_sh_ddr_awvalid || ddr.cl_sh_ddr_awaddr != aw_p_addr ||
                                ddr.cl_sh_ddr_awlen != aw_p_len)) proto_err++;
                if (w_wait && (!ddr.cl_sh_ddr_wvalid || ddr.cl_sh_ddr_wdata != w_p_data ||
                               ddr.cl_sh_ddr_wlast != w_p_last)) proto_err++;
                if (ar_wait && (!ddr.cl_sh_ddr_arvalid || ddr.cl_sh_ddr_araddr != ar_p_addr ||
                                ddr.cl_sh_ddr_arlen != ar_p_len)) proto_err++;
                if (ddr.cl_sh_ddr_awvalid && ddr.cl_sh_ddr_wvalid) proto_err++;
                if (ddr.cl_sh_ddr_awvalid || ddr.cl_sh_ddr_wvalid || ddr.cl_sh_ddr_arvalid)
                    valid_seen++;

                if (b_taken) begin ddr.sh_cl_ddr_bvalid = 0; b_taken = 0; end
                if (!ddr.sh_cl_ddr_bvalid && b_pend > 0 && coin(ready_pct)) begin
                    ddr.sh_cl_ddr_bvalid = 1;
                    ddr.sh_cl_ddr_bresp  = (b_cnt == bresp_err_burst) ? 2'b10 : 2'b00;
                    ddr.sh_cl_ddr_bid    = 16'($urandom);
                end

                if (r_taken) begin
                    ddr.sh_cl_ddr_rvalid = 0; r_taken = 0; r_beat++;
                    if (r_beat > m_len) begin r_beat = 0; void'(rq.pop_front()); end
                end
                if (!ddr.sh_cl_ddr_rvalid && rq.size() > 0 && coin(ready_pct)) begin
                    ra = rq[0] + 64'(r_beat) * 64'd64;
                    ddr.sh_cl_ddr_rdata = mem.exists(ra) ? mem[ra] : '0;
                    if (ra == corrupt_addr) ddr.sh_cl_ddr_rdata[5] = ~ddr.sh_cl_ddr_rdata[5];
                    ddr.sh_cl_ddr_rresp  = (ra == rresp_err_addr) ? 2'b10 : 2'b00;
                    ddr.sh_cl_ddr_rlast  = (r_beat == m_len) ^ (ra == rlast_err_addr);
                    ddr.sh_cl_ddr_rid    = 16'($urandom);
                    ddr.sh_cl_ddr_rvalid = 1;
                end

                ddr.sh_cl_ddr_awready = coin(ready_pct);
                ddr.sh_cl_ddr_wready  = coin(ready_pct);
                ddr.sh_cl_ddr_arready = coin(ready_pct);

                if (ddr.cl_sh_ddr_awvalid && ddr.sh_cl_ddr_awready) begin
                    ea = m_base + 64'(aw_cnt) * step_bytes(m_len);
                    check("awaddr", ddr.cl_sh_ddr_awaddr, ea);
                    check("awlen", 64'(ddr.cl_sh_ddr_awlen), 64'(m_len));
                    check("aw_fixed", {ddr.cl_sh_ddr_awid, ddr.cl_sh_ddr_awsize,
                                       ddr.cl_sh_ddr_awburst}, {16'd0, 3'd6, 2'b01});
                    aw_cnt++; w_beat = 0; w_addr = ea;
                end
                if (ddr.cl_sh_ddr_wvalid && ddr.sh_cl_ddr_wready) begin
                    word = w_addr[31:0] ^ m_seed;
                    check("wdata", ddr.cl_sh_ddr_wdata[63:0], {word, word});
                    check("wdata_rep", 64'(ddr.cl_sh_ddr_wdata == {16{word}}), 64'd1);
                    check("wlast", 64'(ddr.cl_sh_ddr_wlast), 64'(w_beat == m_len));
                    check("wstrb_wid", {ddr.cl_sh_ddr_wstrb[47:0], ddr.cl_sh_ddr_wid},
                          {48'hFFFF_FFFF_FFFF, 16'd0});
                    mem[w_addr] = ddr.cl_sh_ddr_wdata;
                    if (w_beat == m_len) b_pend++;
                    w_cnt++; w_beat++; w_addr += 64'd64;
                end
                if (ddr.sh_cl_ddr_bvalid && ddr.cl_sh_ddr_bready) begin
                    b_taken = 1; b_pend--; b_cnt++;
                end
                if (ddr.cl_sh_ddr_arvalid && ddr.sh_cl_ddr_arready) begin
                    ea = m_base + 64'(ar_cnt) * step_bytes(m_len);
                    check("araddr", ddr.cl_sh_ddr_araddr, ea);
                    check("arlen", 64'(ddr.cl_sh_ddr_arlen), 64'(m_len));
                    check("ar_fixed", {ddr.cl_sh_ddr_arid, ddr.cl_sh_ddr_arsize,
                                       ddr.cl_sh_ddr_arburst}, {16'd0, 3'd6, 2'b01});
                    rq.push_back(ea); ar_cnt++;
                end
                if (ddr.sh_cl_ddr_rvalid && ddr.cl_sh_ddr_rready) begin
                    r_taken = 1; r_cnt++;
                end

                aw_wait = ddr.cl_sh_ddr_awvalid && !ddr.sh_cl_ddr_awready;
                w_wait  = ddr.cl_sh_ddr_wvalid && !ddr.sh_cl_ddr_wready;
                ar_wait = ddr.cl_sh_ddr_arvalid && !ddr.sh_cl_ddr_arready;
                aw_p_addr = ddr.cl_sh_ddr_awaddr; aw_p_len = ddr.cl_sh_ddr_awlen;
                ar_p_addr = ddr.cl_sh_ddr_araddr; ar_p_len = ddr.cl_sh_ddr_arlen;
                w_p_data  = ddr.cl_sh_ddr_wdata;  w_p_last = ddr.cl_sh_ddr_wlast;
            end
        end
    end

    task automatic step();
        @(negedge clk_core);
        #1;
    endtask

    task automatic setup_model(input logic [63:0] base, input int len, input int num,
                               input logic [31:0] seed, input int pct);
        m_base = base; m_len = len; m_num = num; m_seed = seed; ready_pct = pct;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; valid_seen = 0; proto_err = 0;
        mem.delete();
    endtask

    task automatic drive_start(input logic [63:0] base, input logic [7:0] len,
                               input logic [15:0] num, input logic [31:0] seed);
        cfg_base = base; cfg_len = len; cfg_num = num; cfg_seed = seed; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full run: expected error count derived from the injection knobs over every burst and beat.
    task automatic run_case(input string name, input logic [63:0] base, input int len,
                            input int num, input int pct, input bit hold);
        int          exp_err;
        int          cyc;
        logic [63:0] a;
        logic [31:0] seed;
        seed = $urandom;
        setup_model(base, len, num, seed, pct);
        exp_err = 0;
        for (int k = 0; k < num; k++) begin
            if (k == bresp_err_burst) exp_err++;
            for (int b = 0; b <= len; b++) begin
                a = base + 64'(k) * step_bytes(len) + 64'(b) * 64'd64;
                if (a == rresp_err_addr || a == rlast_err_addr || (ChkEn && a == corrupt_addr))
                    exp_err++;
            end
        end
        drive_start(base, 8'(len), 16'(num), seed);
        check({name, "_busy"}, 64'(busy), 64'd1);
        // A start while busy must be ignored.
        drive_start(64'h0, 8'd2, 16'd0, 32'd0);
        cyc = 0;
        while (!done && cyc < 20000) begin step(); cyc++; end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        check({name, "_cfg_err"}, 64'(cfg_err), 64'd0);
        check({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        check({name, "_aw"}, 64'(aw_cnt), 64'(num));
        check({name, "_w"}, 64'(w_cnt), 64'(num * (len + 1)));
        check({name, "_b"}, 64'(b_cnt), 64'(num));
        check({name, "_ar"}, 64'(ar_cnt), 64'(num));
        check({name, "_r"}, 64'(r_cnt), 64'(num * (len + 1)));
        check({name, "_proto"}, 64'(proto_err), 64'd0);
        if (hold) begin
            repeat (3) step();
            check({name, "_done_hold"}, 64'(done), 64'd1);
        end
    endtask

    task automatic run_nop(input string name, input logic [7:0] len, input logic [15:0] num,
                           input logic exp_cerr);
        setup_model(64'h3000, int'(len), int'(num), 32'h0, 100);
        drive_start(64'h3000, len, num, $urandom);
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_cfg_err"}, 64'(cfg_err), 64'(exp_cerr));
        check({name, "_err_clr"}, 64'(err_cnt), 64'd0);
        repeat (5) step();
        check({name, "_no_valid"}, 64'(valid_seen), 64'd0);
        check({name, "_done_hold"}, 64'(done), 64'd1);
    endtask

    initial begin : main
        logic [7:0] legal [7];
        int cyc;
        legal = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63};
        rst_n = 1'b0; start = 1'b0;
        cfg_base = 0; cfg_len = 0; cfg_num = 0; cfg_seed = 0;
        setup_model(64'h0, 0, 0, 32'h0, 100);
        repeat (3) step();
        check("rst_status", {busy, done, cfg_err, err_cnt}, 19'd0);
        check("rst_valids", {ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid, ddr.cl_sh_ddr_arvalid,
                             ddr.cl_sh_ddr_bready, ddr.cl_sh_ddr_rready}, 5'd0);
        check("rst_awaddr", ddr.cl_sh_ddr_awaddr, 64'd0);
        check("rst_wdata", ddr.cl_sh_ddr_wdata[63:0], 64'd0);
        rst_n = 1'b1;
        step();

        run_case("directed", 64'h1000, 3, 4, 100, 1'b0);
        run_case("stall", 64'h1000, 3, 4, 45, 1'b1);

        corrupt_addr = 64'h1240;
        run_case("corrupt", 64'h1000, 3, 4, 70, 1'b1);
        corrupt_addr = NoAddr;

        bresp_err_burst = 2;
        run_case("bresp", 64'h1000, 3, 4, 80, 1'b0);
        bresp_err_burst = -1;

        run_nop("bad_len", 8'd2, 16'd4, 1'b1);
        run_nop("num0", 8'd3, 16'd0, 1'b0);

        rresp_err_addr = 64'h5040;
        rlast_err_addr = 64'h50C0;
        run_case("rerr", 64'h5000, 7, 3, 60, 1'b1);
        rlast_err_addr = 64'h5040;
        run_case("rerr_same", 64'h5000, 7, 3, 60, 1'b1);
        rresp_err_addr = NoAddr;
        rlast_err_addr = NoAddr;

        run_case("wrap", 64'hFFFF_FFFF_FFFF_F000, 63, 3, 90, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_case("rand", {$urandom, $urandom} & ~64'hFFF, int'(legal[$urandom_range(0, 6)]),
                     $urandom_range(1, 8), $urandom_range(30, 100), 1'b1);
        end

        // Reset while the third write beat is on the bus.
        setup_model(64'h2000, 7, 2, $urandom, 100);
        drive_start(64'h2000, 8'd7, 16'd2, m_seed);
        cyc = 0;
        while (w_cnt < 2 && cyc < 1000) begin step(); cyc++; end
        check("rst_reach", 64'(w_cnt), 64'd2);
        @(posedge clk_core);
        #2;
        check("rst_wvalid_pre", 64'(ddr.cl_sh_ddr_wvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valids", {ddr.cl_sh_ddr_awvalid, ddr.cl_sh_ddr_wvalid,
                                 ddr.cl_sh_ddr_arvalid, ddr.cl_sh_ddr_bready,
                                 ddr.cl_sh_ddr_rready}, 5'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        run_case("post_rst", 64'h2000, 7, 2, 70, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
